// File: rtl/apb_pkg.sv
// Shared definitions for the round-robin APB master.
//   apb_state_e : APB master sequencing states (IDLE, SETUP, ACCESS)
//   APB_AW      : default APB address width (8-entry register file)
//   APB_DW      : default APB data width
package apb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } apb_state_e;

  localparam int APB_AW = 3;
  localparam int APB_DW = 8;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker.
// Ports:
//   req    in  NREQ           request vector
//   ptr    in  $clog2(NREQ)   index searched first; the search wraps modulo NREQ
//   grant  out NREQ           one-hot grant, zero when req is zero
//   winner out $clog2(NREQ)   encoded index of the granted bit (0 when none)
module rr_arbiter #(
  parameter int NREQ = 2
) (
  input  logic [NREQ-1:0]         req,
  input  logic [$clog2(NREQ)-1:0] ptr,
  output logic [NREQ-1:0]         grant,
  output logic [$clog2(NREQ)-1:0] winner
);

  localparam int PW = $clog2(NREQ);

  logic          found;
  logic [PW-1:0] idx;

  // Walk the requesters starting at ptr; the first set bit wins.
  always_comb begin
    grant  = '0;
    winner = '0;
    found  = 1'b0;
    idx    = '0;
    for (int i = 0; i < NREQ; i++) begin
      idx = PW'((int'(ptr) + i) % NREQ);
      if (!found && req[idx]) begin
        found      = 1'b1;
        grant[idx] = 1'b1;
        winner     = idx;
      end
    end
  end

endmodule

// File: rtl/apb_rr_master.sv
// Round-robin arbitrating APB master: shares one APB slave among NREQ local
// requesters, sequences SETUP/ACCESS, and returns read data and error status
// with a one-cycle done pulse. A wait-state timeout forces an error
// completion if the slave never raises pready.
// Ports:
//   pclk, preset_n          clock, asynchronous active-low reset
//   req/req_write           per-requester request and direction (1=write)
//   req_addr/req_wdata      packed per-requester address / write data
//   done                    one-cycle, one-hot completion pulse
//   rsp_rdata/rsp_err       read data of last read / error of last transfer
//   psel..pwdata            APB master outputs (all registered)
//   pready/prdata/pslverr   APB slave response
//
// Requester handshake: a requester raises req[i] with its command fields
// stable and holds it until it sees done[i]. done[i] is the acknowledge; in
// the cycle done[i] is high the requester is masked from arbitration, so it
// may either drop req[i] or keep it high to issue its next command. Dropping
// req[i] before it is granted simply withdraws the request. Once granted the
// transfer runs to completion even if req[i] falls.
module apb_rr_master
  import apb_pkg::*;
#(
  parameter int NREQ    = 2,
  parameter int AW      = APB_AW,
  parameter int DW      = APB_DW,
  parameter int TIMEOUT = 15
) (
  input  logic             pclk,
  input  logic             preset_n,
  input  logic [NREQ-1:0]  req,
  input  logic [NREQ-1:0]  req_write,
  input  logic [NREQ*AW-1:0] req_addr,
  input  logic [NREQ*DW-1:0] req_wdata,
  output logic [NREQ-1:0]  done,
  output logic [DW-1:0]    rsp_rdata,
  output logic             rsp_err,
  output logic             psel,
  output logic             penable,
  output logic             pwrite,
  output logic [AW-1:0]    paddr,
  output logic [DW-1:0]    pwdata,
  input  logic             pready,
  input  logic [DW-1:0]    prdata,
  input  logic             pslverr
);

  localparam int PW = $clog2(NREQ);
  localparam int CW = $clog2(TIMEOUT + 1);

  apb_state_e    state;
  logic [PW-1:0] ptr;
  logic [PW-1:0] win_q;
  logic [CW-1:0] tcnt;
  logic [CW-1:0] tcnt_nxt;
  logic          timeout_hit;

  logic [NREQ-1:0] eligible;
  logic [NREQ-1:0] grant;
  logic [PW-1:0]   win_idx;

  // The requester currently being acknowledged must not win again in the
  // same cycle, otherwise a held req would be serviced twice for one command.
  assign eligible = req & ~done;

  assign tcnt_nxt    = tcnt + CW'(1);
  assign timeout_hit = (tcnt_nxt == CW'(TIMEOUT));

  rr_arbiter #(
    .NREQ (NREQ)
  ) u_arb (
    .req    (eligible),
    .ptr    (ptr),
    .grant  (grant),
    .winner (win_idx)
  );

  always_ff @(posedge pclk or negedge preset_n) begin
    if (!preset_n) begin
      state     <= IDLE;
      ptr       <= '0;
      win_q     <= '0;
      tcnt      <= '0;
      done      <= '0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
      psel      <= 1'b0;
      penable   <= 1'b0;
      pwrite    <= 1'b0;
      paddr     <= '0;
      pwdata    <= '0;
    end else begin
      done <= '0;
      case (state)
        IDLE: begin
          if (|grant) begin
            win_q   <= win_idx;
            pwrite  <= req_write[win_idx];
            paddr   <= req_addr[int'(win_idx)*AW +: AW];
            pwdata  <= req_wdata[int'(win_idx)*DW +: DW];
            psel    <= 1'b1;
            penable <= 1'b0;
            state   <= SETUP;
          end
        end

        SETUP: begin
          penable <= 1'b1;
          tcnt    <= '0;
          state   <= ACCESS;
        end

        ACCESS: begin
          // A slave response in the final allowed cycle still counts as a
          // normal completion; the timeout only fires on pready=0.
          if (pready || timeout_hit) begin
            psel        <= 1'b0;
            penable     <= 1'b0;
            done[win_q] <= 1'b1;
            ptr         <= (win_q == PW'(NREQ - 1)) ? '0 : win_q + PW'(1);
            state       <= IDLE;
            if (pready) begin
              rsp_err <= pslverr;
              if (!pwrite) rsp_rdata <= prdata;
            end else begin
              rsp_err <= 1'b1;
              if (!pwrite) rsp_rdata <= '0;
            end
          end
          if (!pready) tcnt <= tcnt_nxt;
        end

        default: begin
          psel    <= 1'b0;
          penable <= 1'b0;
          state   <= IDLE;
        end
      endcase
    end
  end

endmodule
